// File: rtl/digit_entry_buffer.sv
// Keypad digit buffer for the doorlock datapath: shifts strobed digits in from the right,
// supports backspace and overflow policy, and freezes the code in HOLD until acknowledged.
module digit_entry_buffer #(
  parameter int DIGIT_W    = 4,
  parameter int MAX_DIGITS = 32,
  parameter int OVF_MODE   = 0,
  localparam int CNT_W     = $clog2(MAX_DIGITS + 1)
) (
  input  logic                          clk,
  input  logic                          buff_rst,
  input  logic                          clear,
  input  logic                          input_v,
  input  logic                          decision,
  input  logic [DIGIT_W-1:0]            data,
  input  logic                          backspace,
  input  logic                          commit,
  input  logic                          ack,
  output logic [DIGIT_W*MAX_DIGITS-1:0] data_out,
  output logic [DIGIT_W-1:0]            msb,
  output logic                          msb_v,
  output logic [CNT_W-1:0]              count,
  output logic                          empty,
  output logic                          full,
  output logic                          code_v,
  output logic                          overflow
);

  localparam int                          BUF_W    = DIGIT_W * MAX_DIGITS;
  localparam logic [DIGIT_W-1:0]          FILL     = {DIGIT_W{1'b1}};
  localparam logic [BUF_W-1:0]            FILL_ALL = {MAX_DIGITS{FILL}};
  localparam logic [CNT_W-1:0]            CNT_MAX  = CNT_W'(MAX_DIGITS);

  typedef enum logic {ENTRY, HOLD} state_t;

  state_t             r_state, w_state_n;
  logic [BUF_W-1:0]   r_data, w_data_n;
  logic [DIGIT_W-1:0] r_msb, w_msb_n;
  logic               r_msb_v, w_msb_v_n;
  logic [CNT_W-1:0]   r_count, w_count_n;
  logic               r_ovf, w_ovf_n;
  logic               w_digit;
  logic [BUF_W-1:0]   w_shift_in;

  assign w_digit    = input_v && decision;
  assign w_shift_in = {r_data[BUF_W-DIGIT_W-1:0], data};

  always_ff @(posedge clk or posedge buff_rst) begin
    if (buff_rst) begin
      r_state <= ENTRY;
      r_data  <= FILL_ALL;
      r_msb   <= FILL;
      r_msb_v <= 1'b0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_data  <= w_data_n;
      r_msb   <= w_msb_n;
      r_msb_v <= w_msb_v_n;
      r_count <= w_count_n;
      r_ovf   <= w_ovf_n;
    end
  end

  // One event wins per cycle in ENTRY (clear > commit > backspace > digit); HOLD only flushes.
  always_comb begin
    w_state_n = r_state;
    w_data_n  = r_data;
    w_msb_n   = r_msb;
    w_msb_v_n = 1'b0;
    w_count_n = r_count;
    w_ovf_n   = 1'b0;
    case (r_state)
      ENTRY: begin
        if (clear) begin
          w_data_n  = FILL_ALL;
          w_count_n = '0;
        end else if (commit) begin
          if (r_count != '0) w_state_n = HOLD;
        end else if (backspace) begin
          if (r_count != '0) begin
            w_data_n  = {FILL, r_data[BUF_W-1:DIGIT_W]};
            w_count_n = r_count - 1'b1;
          end
        end else if (w_digit) begin
          if (r_count < CNT_MAX) begin
            w_data_n  = w_shift_in;
            w_msb_n   = r_data[BUF_W-1 -: DIGIT_W];
            w_msb_v_n = 1'b1;
            w_count_n = r_count + 1'b1;
          end else if (OVF_MODE == 0) begin
            w_data_n  = w_shift_in;
            w_msb_n   = r_data[BUF_W-1 -: DIGIT_W];
            w_msb_v_n = 1'b1;
            w_ovf_n   = 1'b1;
          end else begin
            w_ovf_n   = 1'b1;
          end
        end
      end
      HOLD: begin
        if (ack || clear) begin
          w_state_n = ENTRY;
          w_data_n  = FILL_ALL;
          w_count_n = '0;
        end
      end
      default: w_state_n = ENTRY;
    endcase
  end

  assign data_out = r_data;
  assign msb      = r_msb;
  assign msb_v    = r_msb_v;
  assign count    = r_count;
  assign empty    = (r_count == '0);
  assign full     = (r_count == CNT_MAX);
  assign code_v   = (r_state == HOLD);
  assign overflow = r_ovf;

endmodule

// File: tb/tb_digit_entry_buffer.sv
// Bench for digit_entry_buffer: two instances (shift-out and reject overflow policy) driven
// by the same directed vectors, checked every cycle against a digit-list model.
module tb_digit_entry_buffer;

  logic        clk = 1'b0;
  logic        buff_rst;
  logic        clear, inputV, decision, backspace, commit, ack;
  logic [3:0]  data;

  logic [15:0] dataOut [2];
  logic [3:0]  msbOut  [2];
  logic        msbV    [2];
  logic [2:0]  countOut[2];
  logic        emptyOut[2];
  logic        fullOut [2];
  logic        codeV   [2];
  logic        ovfOut  [2];

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // Model: list of entered digits, oldest at index 0.
  logic [3:0] mDig [2][4];
  int         mCnt [2];
  bit         mHold[2];
  logic [3:0] mMsb [2];
  bit         mMsbV[2];
  bit         mOvf [2];

  always #5 clk = ~clk;

  digit_entry_buffer #(.DIGIT_W(4), .MAX_DIGITS(4), .OVF_MODE(0)) u0 (
    .clk(clk), .buff_rst(buff_rst), .clear(clear), .input_v(inputV), .decision(decision),
    .data(data), .backspace(backspace), .commit(commit), .ack(ack),
    .data_out(dataOut[0]), .msb(msbOut[0]), .msb_v(msbV[0]), .count(countOut[0]),
    .empty(emptyOut[0]), .full(fullOut[0]), .code_v(codeV[0]), .overflow(ovfOut[0]));

  digit_entry_buffer #(.DIGIT_W(4), .MAX_DIGITS(4), .OVF_MODE(1)) u1 (
    .clk(clk), .buff_rst(buff_rst), .clear(clear), .input_v(inputV), .decision(decision),
    .data(data), .backspace(backspace), .commit(commit), .ack(ack),
    .data_out(dataOut[1]), .msb(msbOut[1]), .msb_v(msbV[1]), .count(countOut[1]),
    .empty(emptyOut[1]), .full(fullOut[1]), .code_v(codeV[1]), .overflow(ovfOut[1]));

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] expData(input int m);
    logic [15:0] v;
    for (int p = 0; p < 4; p++)
      v[p*4 +: 4] = (p < mCnt[m]) ? mDig[m][mCnt[m]-1-p] : 4'hF;
    return v;
  endfunction

  function automatic void modelReset();
    for (int m = 0; m < 2; m++) begin
      mCnt[m] = 0; mHold[m] = 0; mMsb[m] = 4'hF; mMsbV[m] = 0; mOvf[m] = 0;
    end
  endfunction

  function automatic void modelStep();
    for (int m = 0; m < 2; m++) begin
      mMsbV[m] = 0;
      mOvf[m]  = 0;
      if (mHold[m]) begin
        if (ack || clear) begin mHold[m] = 0; mCnt[m] = 0; end
      end else if (clear) begin
        mCnt[m] = 0;
      end else if (commit) begin
        if (mCnt[m] > 0) mHold[m] = 1;
      end else if (backspace) begin
        if (mCnt[m] > 0) mCnt[m]--;
      end else if (inputV && decision) begin
        if (mCnt[m] < 4) begin
          mMsb[m] = 4'hF; mMsbV[m] = 1;
          mDig[m][mCnt[m]] = data; mCnt[m]++;
        end else if (m == 0) begin
          mMsb[m] = mDig[m][0]; mMsbV[m] = 1; mOvf[m] = 1;
          for (int i = 0; i < 3; i++) mDig[m][i] = mDig[m][i+1];
          mDig[m][3] = data;
        end else begin
          mOvf[m] = 1;
        end
      end
    end
  endfunction

  // One clock step with the given inputs; model advances on the same edge as the DUTs.
  task automatic applyStimulus(input logic clr, input logic cmt, input logic bs,
                               input logic iv, input logic dec, input logic [3:0] d,
                               input logic ak);
    clear = clr; commit = cmt; backspace = bs; inputV = iv; decision = dec; data = d; ack = ak;
    @(posedge clk);
    modelStep();
    #1;
    clear = 0; commit = 0; backspace = 0; inputV = 0; decision = 0; data = 4'h0; ack = 0;
  endtask

  task automatic digit(input logic [3:0] d);
    applyStimulus(0, 0, 0, 1, 1, d, 0);
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int m = 0; m < 2; m++) begin
        checkOutput($sformatf("data_out[%0d]", m), 32'(dataOut[m]), 32'(expData(m)));
        checkOutput($sformatf("count[%0d]", m), 32'(countOut[m]), 32'(mCnt[m]));
        checkOutput($sformatf("empty[%0d]", m), 32'(emptyOut[m]), 32'(mCnt[m] == 0));
        checkOutput($sformatf("full[%0d]", m), 32'(fullOut[m]), 32'(mCnt[m] == 4));
        checkOutput($sformatf("msb[%0d]", m), 32'(msbOut[m]), 32'(mMsb[m]));
        checkOutput($sformatf("msb_v[%0d]", m), 32'(msbV[m]), 32'(mMsbV[m]));
        checkOutput($sformatf("code_v[%0d]", m), 32'(codeV[m]), 32'(mHold[m]));
        checkOutput($sformatf("overflow[%0d]", m), 32'(ovfOut[m]), 32'(mOvf[m]));
      end
    end
  end

  initial begin
    clear = 0; commit = 0; backspace = 0; inputV = 0; decision = 0; data = 4'h0; ack = 0;
    buff_rst = 1'b1;
    modelReset();
    started = 1'b1;
    #12;
    checkOutput("reset data", 32'(dataOut[0]), 32'h0000FFFF);
    checkOutput("reset count", 32'(countOut[0]), 32'd0);
    checkOutput("reset empty", 32'(emptyOut[0]), 32'd1);
    checkOutput("reset code_v", 32'(codeV[0]), 32'd0);
    @(posedge clk); #2;
    buff_rst = 1'b0;

    digit(4'h1); digit(4'h2); digit(4'h3);
    checkOutput("three digits", 32'(dataOut[0]), 32'h0000F123);
    checkOutput("three count", 32'(countOut[0]), 32'd3);
    applyStimulus(0, 0, 1, 0, 0, 4'h0, 0);
    checkOutput("backspace", 32'(dataOut[0]), 32'h0000FF12);
    applyStimulus(0, 0, 1, 0, 0, 4'h0, 0);
    applyStimulus(0, 0, 1, 0, 0, 4'h0, 0);
    applyStimulus(0, 0, 1, 0, 0, 4'h0, 0);
    checkOutput("bs to empty", 32'(dataOut[0]), 32'h0000FFFF);
    checkOutput("bs empty count", 32'(countOut[0]), 32'd0);

    applyStimulus(0, 0, 0, 1, 0, 4'h6, 0);
    checkOutput("non-digit key", 32'(countOut[0]), 32'd0);

    digit(4'h1); digit(4'h2); digit(4'h3); digit(4'h4);
    checkOutput("full flag", 32'(fullOut[0]), 32'd1);
    digit(4'h5);
    checkOutput("ovf0 data", 32'(dataOut[0]), 32'h00002345);
    checkOutput("ovf0 count", 32'(countOut[0]), 32'd4);
    checkOutput("ovf0 msb", 32'(msbOut[0]), 32'h1);
    checkOutput("ovf0 msb_v", 32'(msbV[0]), 32'd1);
    checkOutput("ovf0 pulse", 32'(ovfOut[0]), 32'd1);
    checkOutput("ovf1 data", 32'(dataOut[1]), 32'h00001234);
    checkOutput("ovf1 msb_v", 32'(msbV[1]), 32'd0);
    checkOutput("ovf1 pulse", 32'(ovfOut[1]), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 0);
    checkOutput("ovf pulse drop", 32'(ovfOut[0]), 32'd0);

    applyStimulus(1, 0, 0, 0, 0, 4'h0, 0);
    digit(4'h7); digit(4'h8);
    applyStimulus(0, 1, 0, 0, 0, 4'h0, 0);
    checkOutput("commit hold", 32'(codeV[0]), 32'd1);
    digit(4'h9);
    applyStimulus(0, 0, 1, 0, 0, 4'h0, 0);
    applyStimulus(0, 1, 0, 0, 0, 4'h0, 0);
    checkOutput("hold frozen", 32'(dataOut[0]), 32'h0000FF78);
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 1);
    checkOutput("ack flush", 32'(dataOut[0]), 32'h0000FFFF);
    checkOutput("ack code_v", 32'(codeV[0]), 32'd0);

    digit(4'h7);
    applyStimulus(0, 1, 0, 1, 1, 4'h9, 0);
    checkOutput("commit+digit", 32'(dataOut[0]), 32'h0000FFF7);
    checkOutput("commit+digit hold", 32'(codeV[0]), 32'd1);
    applyStimulus(1, 0, 0, 0, 0, 4'h0, 1);
    checkOutput("ack+clear", 32'(countOut[0]), 32'd0);

    digit(4'h7);
    applyStimulus(1, 1, 0, 0, 0, 4'h0, 0);
    checkOutput("clear+commit", 32'(codeV[0]), 32'd0);
    applyStimulus(0, 1, 0, 0, 0, 4'h0, 0);
    checkOutput("commit empty", 32'(codeV[0]), 32'd0);

    digit(4'h3);
    applyStimulus(0, 1, 0, 0, 0, 4'h0, 0);
    #1;
    buff_rst = 1'b1;
    modelReset();
    #1;
    checkOutput("async data", 32'(dataOut[0]), 32'h0000FFFF);
    checkOutput("async code_v", 32'(codeV[0]), 32'd0);
    checkOutput("async count", 32'(countOut[0]), 32'd0);
    checkOutput("async empty", 32'(emptyOut[0]), 32'd1);
    #1;
    buff_rst = 1'b0;
    @(posedge clk); #1;
    digit(4'hA);
    checkOutput("post reset digit", 32'(dataOut[0]), 32'h0000FFFA);
    applyStimulus(0, 0, 0, 0, 0, 4'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
